// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder: FSM states, Gray codes of the
// {A,B} pair, direction levels and the legal "up" successor function.
package quad_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

   localparam logic [1:0] Q00 = 2'b00;
   localparam logic [1:0] Q01 = 2'b01;
   localparam logic [1:0] Q11 = 2'b11;
   localparam logic [1:0] Q10 = 2'b10;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Up rotation is 00 -> 01 -> 11 -> 10 -> 00.
   function automatic logic [1:0] next_up(input logic [1:0] s);
      logic [1:0] n;
      case (s)
         Q00:     n = Q01;
         Q01:     n = Q11;
         Q11:     n = Q10;
         default: n = Q00;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One quadrature channel: multi-flop synchroniser followed by a persistence
// filter that accepts a new level only after FILTER_LEN consecutive samples.
module quad_input_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic Clk,
   input  logic reset,
   input  logic i_load,
   input  logic i_raw,
   output logic o_filt
);

   localparam int CNT_W = $clog2(FILTER_LEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_filt;
   logic                   w_synced;

   assign w_synced = r_sync[SYNC_STAGES-1];
   assign o_filt   = r_filt;

   // NOTE: non-blocking assignments make every stage of the chain sample the
   // previous stage's old value, so the shift takes one flop per edge.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_sync <= '0;
         r_cnt  <= '0;
         r_filt <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
         if (i_load) begin
            r_filt <= w_synced;
            r_cnt  <= '0;
         end else if (w_synced != r_filt) begin
            if (r_cnt == CNT_LAST) begin
               r_filt <= w_synced;
               r_cnt  <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_ONE;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filtered A/B channels feed a settle/track FSM that emits
// a one-cycle Step with a held direction level, or an Error on a double change.
module quadrature_decoder
   import quad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic Clk,
   input  logic reset,
   input  logic A_raw,
   input  logic B_raw,
   output logic Step,
   output logic UpOrDown,
   output logic Error
);

   localparam int SETTLE = SYNC_STAGES + FILTER_LEN;
   localparam int SET_W  = $clog2(SETTLE) + 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
   localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);

   state_t           r_state;
   logic [SET_W-1:0] r_settle;
   logic [1:0]       r_prev;
   logic             r_step;
   logic             r_err;
   logic             r_dir;

   logic       w_load;
   logic       w_filt_a;
   logic       w_filt_b;
   logic [1:0] w_cur;

   assign w_load = (r_state == ST_INIT);
   assign w_cur  = {w_filt_a, w_filt_b};

   quad_input_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_filt_a (
      .Clk    (Clk),
      .reset  (reset),
      .i_load (w_load),
      .i_raw  (A_raw),
      .o_filt (w_filt_a)
   );

   quad_input_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_filt_b (
      .Clk    (Clk),
      .reset  (reset),
      .i_load (w_load),
      .i_raw  (B_raw),
      .o_filt (w_filt_b)
   );

   // During settle the filters track their inputs directly, so prev already
   // holds the static input level when decoding starts.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_INIT;
         r_settle <= '0;
         r_prev   <= Q00;
         r_step   <= 1'b0;
         r_err    <= 1'b0;
         r_dir    <= DIR_UP;
      end else begin
         r_prev <= w_cur;
         r_step <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_INIT: begin
               if (r_settle == SETTLE_LAST) begin
                  r_state <= ST_TRACK;
               end else begin
                  r_settle <= r_settle + SETTLE_ONE;
               end
            end
            ST_TRACK: begin
               if (w_cur != r_prev) begin
                  if (w_cur == next_up(r_prev)) begin
                     r_step <= 1'b1;
                     r_dir  <= DIR_UP;
                  end else if (r_prev == next_up(w_cur)) begin
                     r_step <= 1'b1;
                     r_dir  <= DIR_DOWN;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign Step     = r_step;
   assign Error    = r_err;
   assign UpOrDown = r_dir;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: directed phases plus a random walk, all checked
// cycle by cycle against a history-based reference model.
module tb_quadrature_decoder;

   localparam int S    = 2;
   localparam int F    = 4;
   localparam int N    = S + F;
   localparam int HMAX = 16384;

   logic Clk;
   logic reset;
   logic A_raw;
   logic B_raw;
   logic Step;
   logic UpOrDown;
   logic Error;

   int total;
   int bad;

   quadrature_decoder #(
      .SYNC_STAGES (S),
      .FILTER_LEN  (F)
   ) dut (
      .Clk      (Clk),
      .reset    (reset),
      .A_raw    (A_raw),
      .B_raw    (B_raw),
      .Step     (Step),
      .UpOrDown (UpOrDown),
      .Error    (Error)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #1ms;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   // Reference model: raw history since reset release; the filtered level flips
   // when the last F synchronised samples all disagree with it.
   logic       ha [HMAX];
   logic       hb [HMAX];
   int         mk;
   logic       m_fa;
   logic       m_fb;
   logic [1:0] m_prev;
   logic       e_step;
   logic       e_err;
   logic       e_dir;
   logic [3:0] mctr;

   logic [3:0] ctr;
   int         phase_steps;
   int         phase_errs;
   int         phase_start;
   int         first_step;
   int         cyc;

   function automatic logic syn(input int ch, input int idx);
      if (idx < 0) return 1'b0;
      return (ch == 0) ? ha[idx] : hb[idx];
   endfunction

   function automatic logic window_differs(input int ch, input logic filt);
      for (int j = 0; j < F; j++) begin
         if (syn(ch, mk - S - j) == filt) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int gpos(input logic [1:0] c);
      case (c)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      mk     = 0;
      m_fa   = 1'b0;
      m_fb   = 1'b0;
      m_prev = 2'b00;
      e_step = 1'b0;
      e_err  = 1'b0;
      e_dir  = 1'b1;
   endtask

   task automatic model_edge();
      logic [1:0] cur;
      logic       na;
      logic       nb;
      int         d;
      if (mk >= HMAX) begin
         $display("FAIL model: history overflow");
         $fatal(1, "history overflow");
      end
      ha[mk] = A_raw;
      hb[mk] = B_raw;
      if (mk < N) begin
         m_prev = {m_fa, m_fb};
         m_fa   = syn(0, mk - S);
         m_fb   = syn(1, mk - S);
         e_step = 1'b0;
         e_err  = 1'b0;
      end else begin
         cur    = {m_fa, m_fb};
         d      = (gpos(cur) - gpos(m_prev) + 4) % 4;
         e_step = (d == 1) || (d == 3);
         e_err  = (d == 2);
         if (d == 1) e_dir = 1'b1;
         if (d == 3) e_dir = 1'b0;
         if (e_step) mctr = e_dir ? mctr + 4'd1 : mctr - 4'd1;
         m_prev = cur;
         na = window_differs(0, m_fa) ? ~m_fa : m_fa;
         nb = window_differs(1, m_fb) ? ~m_fb : m_fb;
         m_fa = na;
         m_fb = nb;
      end
      mk++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic a, input logic b);
      A_raw = a;
      B_raw = b;
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      check("step", {31'd0, Step}, {31'd0, e_step});
      check("error", {31'd0, Error}, {31'd0, e_err});
      check("updown", {31'd0, UpOrDown}, {31'd0, e_dir});
      if (Step === 1'b1) begin
         phase_steps++;
         ctr = (UpOrDown === 1'b1) ? ctr + 4'd1 : ctr - 4'd1;
         if (first_step < 0) first_step = cyc - phase_start;
      end
      if (Error === 1'b1) phase_errs++;
      cyc++;
   endtask

   task automatic hold(input logic a, input logic b, input int n);
      for (int i = 0; i < n; i++) tick(a, b);
   endtask

   task automatic new_phase();
      phase_steps = 0;
      phase_errs  = 0;
      phase_start = cyc;
      first_step  = -1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_step", {31'd0, Step}, 32'd0);
      check("rst_error", {31'd0, Error}, 32'd0);
      check("rst_updown", {31'd0, UpOrDown}, 32'd1);
      @(posedge Clk);
      @(negedge Clk);
      check("rst_hold_step", {31'd0, Step}, 32'd0);
      reset = 1'b0;
   endtask

   logic [1:0] gseq [4];
   logic [1:0] lvl;
   int         gi;
   int         act;
   int         len;
   int         glen;
   int         bit_sel;

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      ctr   = 4'd0;
      mctr  = 4'd0;
      gseq  = '{2'b00, 2'b01, 2'b11, 2'b10};
      new_phase();
      model_reset();

      // 1: reset with both inputs high, then quiet settle and static tracking
      reset = 1'b0;
      A_raw = 1'b1;
      B_raw = 1'b1;
      #1 reset = 1'b1;
      #1;
      check("init_step", {31'd0, Step}, 32'd0);
      check("init_error", {31'd0, Error}, 32'd0);
      check("init_updown", {31'd0, UpOrDown}, 32'd1);
      repeat (2) @(negedge Clk);
      reset = 1'b0;
      hold(1'b1, 1'b1, 12);
      check("p1_quiet_steps", phase_steps, 32'd0);
      check("p1_quiet_errs", phase_errs, 32'd0);
      hold(1'b1, 1'b0, 10);
      hold(1'b0, 1'b0, 10);

      // 2: up sequence with latency check
      new_phase();
      ctr  = 4'd0;
      mctr = 4'd0;
      hold(1'b0, 1'b1, 10);
      check("p2_latency", first_step, 32'd6);
      hold(1'b1, 1'b1, 10);
      hold(1'b1, 1'b0, 10);
      hold(1'b0, 1'b0, 10);
      check("p2_steps", phase_steps, 32'd4);
      check("p2_ctr", {28'd0, ctr}, 32'd4);
      check("p2_dir", {31'd0, UpOrDown}, 32'd1);

      // 3: reverse sequence, then one more to wrap the counter
      new_phase();
      hold(1'b1, 1'b0, 10);
      check("p3_first_dir", {31'd0, UpOrDown}, 32'd0);
      hold(1'b1, 1'b1, 10);
      hold(1'b0, 1'b1, 10);
      hold(1'b0, 1'b0, 10);
      check("p3_steps", phase_steps, 32'd4);
      check("p3_ctr", {28'd0, ctr}, 32'd0);
      hold(1'b1, 1'b0, 10);
      check("p3_wrap", {28'd0, ctr}, 32'd15);
      hold(1'b0, 1'b0, 10);

      // 4: short glitch rejected, minimum-length pulse accepted
      new_phase();
      hold(1'b0, 1'b0, 5);
      hold(1'b1, 1'b0, F - 1);
      hold(1'b0, 1'b0, 10);
      check("p4_glitch_steps", phase_steps, 32'd0);
      check("p4_glitch_errs", phase_errs, 32'd0);
      hold(1'b1, 1'b0, F);
      hold(1'b0, 1'b0, 10);
      check("p4_pulse_steps", phase_steps, 32'd2);
      check("p4_dir", {31'd0, UpOrDown}, 32'd1);
      check("p4_ctr", {28'd0, ctr}, 32'd0);

      // 5: simultaneous change on both channels
      new_phase();
      hold(1'b1, 1'b1, 10);
      check("p5_errs", phase_errs, 32'd1);
      check("p5_steps", phase_steps, 32'd0);
      check("p5_dir", {31'd0, UpOrDown}, 32'd1);
      hold(1'b0, 1'b1, 10);
      hold(1'b0, 1'b0, 10);
      check("p5_down_dir", {31'd0, UpOrDown}, 32'd0);

      // 6: reset in the middle of a filter count
      new_phase();
      hold(1'b0, 1'b1, 3);
      do_reset();
      hold(1'b0, 1'b1, 12);
      check("p6_quiet_steps", phase_steps, 32'd0);
      check("p6_quiet_errs", phase_errs, 32'd0);
      hold(1'b1, 1'b1, 10);
      check("p6_track_steps", phase_steps, 32'd1);

      // 7: random walk with glitches, double changes and occasional reset
      lvl = 2'b11;
      for (int i = 0; i < 250; i++) begin
         act = int'($urandom_range(0, 19));
         len = int'($urandom_range(1, 12));
         gi  = gpos(lvl);
         if (act < 12) begin
            lvl = ($urandom_range(0, 1) == 1) ? gseq[(gi + 1) % 4] : gseq[(gi + 3) % 4];
            hold(lvl[1], lvl[0], len);
         end else if (act < 16) begin
            glen    = int'($urandom_range(1, 5));
            bit_sel = int'($urandom_range(0, 1));
            if (bit_sel == 1) hold(~lvl[1], lvl[0], glen);
            else              hold(lvl[1], ~lvl[0], glen);
            hold(lvl[1], lvl[0], len);
         end else if (act < 19) begin
            lvl = ~lvl;
            hold(lvl[1], lvl[0], len);
         end else begin
            do_reset();
            hold(lvl[1], lvl[0], len);
         end
      end
      hold(lvl[1], lvl[0], 12);
      check("p7_ctr", {28'd0, ctr}, {28'd0, mctr});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
